// File: rtl/jtframe_ba_arb_if.sv
// rtl/jtframe_ba_arb_if.sv - Requester-side and SDRAM-bank-side signals of the round-robin bank arbiter
interface jtframe_ba_arb_if #(parameter int AW = 22);
    logic [3:0]      req_rd;
    logic [3:0]      req_wr;
    logic [4*AW-1:0] req_addr;
    logic [63:0]     req_din;
    logic [7:0]      req_dsn;
    logic [3:0]      req_ack;
    logic [3:0]      req_dok;
    logic [3:0]      req_rdy;
    logic [15:0]     req_dout;
    logic            ba_rd;
    logic            ba_wr;
    logic [AW-1:0]   ba_addr;
    logic [15:0]     ba_din;
    logic [1:0]      ba_dsn;
    logic            ba_ack;
    logic            ba_dok;
    logic            ba_rdy;
    logic [15:0]     ba_dout;

    modport master (
        input  req_rd, req_wr, req_addr, req_din, req_dsn,
        output req_ack, req_dok, req_rdy, req_dout,
        output ba_rd, ba_wr, ba_addr, ba_din, ba_dsn,
        input  ba_ack, ba_dok, ba_rdy, ba_dout
    );

    modport slave (
        output req_rd, req_wr, req_addr, req_din, req_dsn,
        input  req_ack, req_dok, req_rdy, req_dout,
        input  ba_rd, ba_wr, ba_addr, ba_din, ba_dsn,
        output ba_ack, ba_dok, ba_rdy, ba_dout
    );
endinterface

// File: rtl/jtframe_ba_arb.sv
// rtl/jtframe_ba_arb.sv - Four-way round-robin arbiter in front of one jtframe_sdram64 bank port
module jtframe_ba_arb #(
    parameter int AW = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    jtframe_ba_arb_if.master      bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic [1:0]      dsn_q, dsn_d;

    logic [3:0]      pend;
    logic [1:0]      winner;
    logic            found;
    logic            pick;

    // Scan from ptr+3 down to ptr so the slot closest to ptr wins last
    always_comb begin
        logic [1:0] idx;
        idx    = 2'd0;
        pend   = bus.req_rd | bus.req_wr;
        winner = ptr_q;
        found  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (pend[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dsn_d   = dsn_q;
        pick    = 1'b0;
        case (state_q)
            IDLE: pick = 1'b1;
            REQ: begin
                if (bus.ba_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                    pick    = bus.ba_rdy;
                end
            end
            XFER:    pick = bus.ba_rdy;
            default: state_d = IDLE;
        endcase
        // Completion and re-selection share a cycle, so owners follow back to back
        if (pick) begin
            if (found) begin
                state_d = REQ;
                owner_d = winner;
                ptr_d   = winner + 2'd1;
                addr_d  = bus.req_addr[int'(winner)*AW +: AW];
                din_d   = bus.req_din[int'(winner)*16 +: 16];
                dsn_d   = bus.req_dsn[int'(winner)*2 +: 2];
                wr_d    = bus.req_wr[winner];
                rd_d    = ~bus.req_wr[winner];
            end else begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 16'd0;
            dsn_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dsn_q   <= dsn_d;
        end
    end

    always_comb begin
        bus.req_ack = 4'd0;
        bus.req_dok = 4'd0;
        bus.req_rdy = 4'd0;
        if (state_q == REQ) bus.req_ack[owner_q] = bus.ba_ack;
        if (state_q == REQ || state_q == XFER) begin
            bus.req_dok[owner_q] = bus.ba_dok;
            bus.req_rdy[owner_q] = bus.ba_rdy;
        end
    end

    assign bus.req_dout = bus.ba_dout;
    assign bus.ba_rd    = rd_q;
    assign bus.ba_wr    = wr_q;
    assign bus.ba_addr  = addr_q;
    assign bus.ba_din   = din_q;
    assign bus.ba_dsn   = dsn_q;
endmodule
